store_buffer: RTL
=================

# store_buffer

Store buffer between the MEM-stage store path and the data memory. It queues up to `DEPTH` word stores and retires one per cycle into the DM write port (`DMen`/`A`/`WD`/`PC8`). Loads with a pending store to the same word are either forwarded from the buffer or stalled, selected at compile time. Decouples store issue from DM write timing; the pipeline stalls only when the buffer is full.

## Interface
- `DEPTH`, 4: number of entries; power of two, 2..16
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears the buffer
- `st_valid`  in  1  store request from MEM stage this cycle
- `st_addr`  in  32  byte address of store; word index = `st_addr[13:2]`
- `st_data`  in  32  store data (full word)
- `st_pc8`  in  32  PC+8 of the store instruction, carried to DM for its write log
- `st_ready`  out  1  buffer can accept a store this cycle
- `drain_hold`  in  1  inhibit retirement this cycle (entry stays at head)
- `dm_en`  out  1  DM write enable
- `dm_A`  out  32  DM address
- `dm_WD`  out  32  DM write data
- `dm_PC8`  out  32  PC+8 for DM log
- `ld_addr`  in  32  byte address of the load currently in MEM
- `ld_hit`  out  1  forwarded data valid on `ld_data`
- `ld_data`  out  32  forwarded word
- `ld_stall`  out  1  load must stall (pending store to same word)
- `empty`  out  1  no entries pending

## Operation
- Circular FIFO: `wr_ptr`, `rd_ptr` (log2 DEPTH bits, wrap modulo DEPTH), `count` (log2 DEPTH + 1 bits). Entry = {addr, data, pc8}.
- Push: `st_valid && st_ready` writes entry at `wr_ptr`, increments it. `st_valid` while `!st_ready` is dropped; the pipeline must hold the store.
- `st_ready = (count != DEPTH)`. Uses current count only; a same-cycle pop does not make room.
- Head: `dm_en = !empty && !drain_hold`. `dm_A`/`dm_WD`/`dm_PC8` = head entry when `!empty`, else all zero.
- Pop: a cycle with `dm_en=1` increments `rd_ptr` at the clock edge. DM always accepts.
- Push and pop in the same cycle: `count` unchanged, both pointers advance.
- Match: a valid entry matches when `entry.addr[13:2] == ld_addr[13:2]`. Only buffered entries are searched; the same-cycle incoming store is not.
- Multiple matches: the youngest entry, closest behind `wr_ptr`, wins.
- Stores to the same word are not merged; every store retires separately and in order.

## Timing
- Reset (`reset`=0, async): pointers and `count` go to 0. Entry storage need not be cleared. Outputs immediately: `st_ready`=1, `empty`=1, `dm_en`=0, `dm_A`/`dm_WD`/`dm_PC8`=0, `ld_hit`=0, `ld_data`=0, `ld_stall`=0.
- Reset mid-operation discards all pending stores; none are written to DM.
- Store accepted at edge N is visible at the DM port in cycle N+1 when the buffer was empty. It writes DM at edge N+1, so minimum latency is 1 cycle.
- Retire throughput: 1 store per cycle. Each `drain_hold` cycle adds 1 cycle.
- Forward/stall outputs are combinational from `ld_addr` and buffer state in the same cycle.
- Entry popped at edge N is no longer matched in cycle N+1. DM holds the data by then.
- Full with `drain_hold`=1: `st_ready`=0 persists until drain resumes.

## Configuration
- `SB_FORWARD_EN` defined:
  - `ld_hit` = match; `ld_data` = youngest matching entry data (0 when no match).
  - `ld_stall` tied 0.
- Undefined:
  - No forwarding datapath is built; `ld_hit`=0 and `ld_data`=0 constant.
  - `ld_stall` = any match; the pipeline holds the load until the entry drains.

## Test plan
- Reset during traffic: push 3 stores with `drain_hold`=1, pull `reset` low mid-cycle -> `empty`=1 and `dm_en`=0 asynchronously; after release no DM write occurs.
- Single store: push addr 0x0000_0010, data 0xDEAD_BEEF, pc8 0x0000_3008 at edge N -> cycle N+1 `dm_en`=1, `dm_A`=0x10, `dm_WD`=0xDEADBEEF, `dm_PC8`=0x3008; cycle N+2 `empty`=1.
- Fill/full: `drain_hold`=1, push DEPTH(4) stores -> `st_ready`=0 after the 4th. Release hold -> retire in push order on 4 consecutive cycles, `st_ready`=1 from the cycle after the first pop.
- Simultaneous push+pop at count=2 -> count stays 2; pointer wrap past entry 3 keeps FIFO order.
- Forwarding: with `SB_FORWARD_EN`, `drain_hold`=1, push 0x20<=0x1111 then 0x22<=0x2222 (same word), load 0x20 -> `ld_hit`=1, `ld_data`=0x2222. Without the macro -> `ld_stall`=1, `ld_hit`=0.
- Load to unmatched word 0x24 -> `ld_hit`=0, `ld_stall`=0 in both builds.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: FIFO of word stores that retire one per cycle into the DM write port.
// Build option SB_FORWARD_EN: forward matching load data instead of stalling the load.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [31:0] st_pc8,
  output logic        st_ready,
  input  logic        drain_hold,
  output logic        dm_en,
  output logic [31:0] dm_A,
  output logic [31:0] dm_WD,
  output logic [31:0] dm_PC8,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic        empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc8;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic push, pop;
  logic match_any;
  logic [PtrW-1:0] idx;
`ifdef SB_FORWARD_EN
  logic [31:0] match_data;
`endif

  logic unused_ld_addr;
  assign unused_ld_addr = ^{ld_addr[31:14], ld_addr[1:0]};

  always_comb begin
    empty    = (count_q == '0);
    st_ready = (count_q != CntW'(DEPTH));
    dm_en    = !empty && !drain_hold;
    dm_A     = '0;
    dm_WD    = '0;
    dm_PC8   = '0;
    if (!empty) begin
      dm_A   = mem_q[rd_ptr_q].addr;
      dm_WD  = mem_q[rd_ptr_q].data;
      dm_PC8 = mem_q[rd_ptr_q].pc8;
    end
    push = st_valid && st_ready;
    pop  = dm_en;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Walk from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    match_any = 1'b0;
    idx       = '0;
`ifdef SB_FORWARD_EN
    match_data = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (mem_q[idx].addr[13:2] == ld_addr[13:2])) begin
        match_any = 1'b1;
`ifdef SB_FORWARD_EN
        match_data = mem_q[idx].data;
`endif
      end
    end
  end

`ifdef SB_FORWARD_EN
  assign ld_hit   = match_any;
  assign ld_data  = match_data;
  assign ld_stall = 1'b0;
`else
  assign ld_hit   = 1'b0;
  assign ld_data  = '0;
  assign ld_stall = match_any;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: st_addr, data: st_data, pc8: st_pc8};
    end
  end

endmodule
